// File: rtl/btn_event_if.sv
// Button event bus: level/tick inputs toward the detector, event pulses back out.
interface btn_event_if;
  logic tick;
  logic btn_in;
  logic press_p;
  logic short_p;
  logic long_p;
  logic rep_p;
  logic held;

  modport master (
    output tick, btn_in,
    input  press_p, short_p, long_p, rep_p, held
  );

  modport slave (
    input  tick, btn_in,
    output press_p, short_p, long_p, rep_p, held
  );
endinterface

// File: rtl/btn_event.sv
// Button event detector: press / short / long / auto-repeat pulses from a debounced level.
// Define BTN_EVENT_REPEAT_EN to build in auto-repeat while held past long-press.
module btn_event #(
  parameter int LONG_T = 1000,
  parameter int REP_T  = 200,
  parameter int CNT_W  = 11
) (
  input  logic     clk,
  input  logic     reset_,
  btn_event_if.slave bus
);

  typedef enum logic [1:0] {ARM, IDLE, PRESS, HOLD} state_t;

  typedef struct packed {
    logic press;
    logic shrt;
    logic lng;
    logic rep;
    logic held;
  } evt_t;

  localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_T - 1);
`ifdef BTN_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_END  = CNT_W'(REP_T - 1);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  evt_t             out_q, out_d;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= ARM;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = '0;
    case (state_q)
      // A button still down from before reset must be seen released first.
      ARM: if (!bus.btn_in) state_d = IDLE;
      IDLE: begin
        cnt_d = '0;
        if (bus.btn_in) begin
          state_d     = PRESS;
          out_d.press = 1'b1;
        end
      end
      PRESS: begin
        // Release is tested first so it wins over a coincident terminal tick.
        if (!bus.btn_in) begin
          state_d    = IDLE;
          out_d.shrt = 1'b1;
        end else if (bus.tick) begin
          if (cnt_q == LONG_END) begin
            state_d   = HOLD;
            cnt_d     = '0;
            out_d.lng = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (!bus.btn_in) begin
          state_d = IDLE;
`ifdef BTN_EVENT_REPEAT_EN
        end else if (bus.tick) begin
          if (cnt_q == REP_END) begin
            cnt_d     = '0;
            out_d.rep = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = ARM;
    endcase
    out_d.held = (state_d == PRESS) || (state_d == HOLD);
  end

  assign bus.press_p = out_q.press;
  assign bus.short_p = out_q.shrt;
  assign bus.long_p  = out_q.lng;
  assign bus.rep_p   = out_q.rep;
  assign bus.held    = out_q.held;

endmodule

// File: tb/tb_btn_event.sv
// Scoreboard bench for btn_event with LONG_T=4, REP_T=2 and a tick every third cycle.
module tb_btn_event;
  logic clk;
  logic reset_;
  btn_event_if bus();

  btn_event #(.LONG_T(4), .REP_T(2), .CNT_W(3)) dut (
    .clk(clk), .reset_(reset_), .bus(bus)
  );

  localparam logic [3:0] EV_PRESS = 4'b1000;
  localparam logic [3:0] EV_SHORT = 4'b0100;
  localparam logic [3:0] EV_LONG  = 4'b0010;
  localparam logic [3:0] EV_REP   = 4'b0001;

`ifdef BTN_EVENT_REPEAT_EN
  localparam logic [15:0] REP_MASK = 16'b0000_0101_0100_0000;
`else
  localparam logic [15:0] REP_MASK = 16'h0000;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] kind;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse seen must match the head of the queue in kind and cycle.
  logic [3:0] mon_pl;
  exp_t       mon_e;
  always @(negedge clk) begin
    mon_pl = {bus.press_p, bus.short_p, bus.long_p, bus.rep_p};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_chk++;
      $display("FAIL missed_event kind=%b due_cyc=%0d now=%0d", sb[0].kind, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (mon_pl != 4'b0000) begin
      n_chk++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_event got=%b want=none cyc=%0d", mon_pl, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc !== cyc || mon_e.kind !== mon_pl)
          $display("FAIL event got=%b@%0d want=%b@%0d", mon_pl, cyc, mon_e.kind, mon_e.cyc);
        else
          n_pass++;
      end
    end
  end

  task automatic exp_ev(input logic [3:0] k);
    exp_t e;
    e.cyc  = cyc + 1;
    e.kind = k;
    sb.push_back(e);
  endtask

  task automatic drive(input logic b, input logic t);
    bus.btn_in = b;
    bus.tick   = t;
    @(posedge clk);
    #1;
  endtask

  // Holds the button for n ticks numbered from 'first'; pulses expected at listed ticks.
  task automatic ticks(input int n, input int first, input int long_at, input logic [15:0] reps);
    for (int k = first; k < first + n; k++) begin
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b0);
      if (k == long_at) exp_ev(EV_LONG);
      if (k < 16 && reps[k]) exp_ev(EV_REP);
      drive(1'b1, 1'b1);
    end
  endtask

  task automatic test_reset;
    reset_     = 1'b0;
    bus.btn_in = 1'b0;
    bus.tick   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.press_p, bus.short_p, bus.long_p, bus.rep_p, bus.held} !== 5'b0)
      $display("FAIL reset_outputs got=%b want=00000",
               {bus.press_p, bus.short_p, bus.long_p, bus.rep_p, bus.held});
    else n_pass++;
    reset_ = 1'b1;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    n_chk++;
    if ({bus.press_p, bus.short_p, bus.long_p, bus.rep_p, bus.held} !== 5'b0)
      $display("FAIL idle_outputs got=%b want=00000",
               {bus.press_p, bus.short_p, bus.long_p, bus.rep_p, bus.held});
    else n_pass++;
  endtask

  task automatic test_long;
    exp_ev(EV_PRESS);
    drive(1'b1, 1'b0);
    n_chk++;
    if (bus.held !== 1'b1) $display("FAIL long_held_rise got=%b want=1", bus.held); else n_pass++;
    ticks(5, 1, 4, 16'h0000);
    n_chk++;
    if (bus.held !== 1'b1) $display("FAIL long_held_hold got=%b want=1", bus.held); else n_pass++;
    drive(1'b0, 1'b0);
    n_chk++;
    if (bus.held !== 1'b0) $display("FAIL long_held_fall got=%b want=0", bus.held); else n_pass++;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    n_chk++;
    if (sb.size() !== 0) $display("FAIL long_pending got=%0d want=0", sb.size()); else n_pass++;
  endtask

  task automatic test_short;
    exp_ev(EV_PRESS);
    drive(1'b1, 1'b0);
    ticks(2, 1, 99, 16'h0000);
    n_chk++;
    if (bus.held !== 1'b1) $display("FAIL short_held got=%b want=1", bus.held); else n_pass++;
    exp_ev(EV_SHORT);
    drive(1'b0, 1'b0);
    n_chk++;
    if (bus.held !== 1'b0) $display("FAIL short_held_fall got=%b want=0", bus.held); else n_pass++;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    n_chk++;
    if (sb.size() !== 0) $display("FAIL short_pending got=%0d want=0", sb.size()); else n_pass++;
  endtask

  task automatic test_repeat;
    exp_ev(EV_PRESS);
    drive(1'b1, 1'b0);
    ticks(10, 1, 4, REP_MASK);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    n_chk++;
    if (bus.held !== 1'b0) $display("FAIL repeat_held got=%b want=0", bus.held); else n_pass++;
    n_chk++;
    if (sb.size() !== 0) $display("FAIL repeat_pending got=%0d want=0", sb.size()); else n_pass++;
  endtask

  task automatic test_race;
    exp_ev(EV_PRESS);
    drive(1'b1, 1'b0);
    ticks(3, 1, 99, 16'h0000);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    exp_ev(EV_SHORT);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    n_chk++;
    if (bus.held !== 1'b0) $display("FAIL race_held got=%b want=0", bus.held); else n_pass++;
    n_chk++;
    if (sb.size() !== 0) $display("FAIL race_pending got=%0d want=0", sb.size()); else n_pass++;
  endtask

  task automatic test_arm;
    reset_     = 1'b0;
    bus.btn_in = 1'b1;
    bus.tick   = 1'b0;
    @(posedge clk);
    #1;
    reset_ = 1'b1;
    ticks(3, 1, 99, 16'h0000);
    drive(1'b1, 1'b0);
    n_chk++;
    if (bus.held !== 1'b0) $display("FAIL arm_held got=%b want=0", bus.held); else n_pass++;
    drive(1'b0, 1'b0);
    exp_ev(EV_PRESS);
    drive(1'b1, 1'b0);
    n_chk++;
    if (bus.held !== 1'b1) $display("FAIL arm_rearm_held got=%b want=1", bus.held); else n_pass++;
    exp_ev(EV_SHORT);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    n_chk++;
    if (sb.size() !== 0) $display("FAIL arm_pending got=%0d want=0", sb.size()); else n_pass++;
  endtask

  task automatic test_reset_hold;
    exp_ev(EV_PRESS);
    drive(1'b1, 1'b0);
    ticks(5, 1, 4, 16'h0000);
    drive(1'b1, 1'b0);
    n_chk++;
    if (bus.held !== 1'b1) $display("FAIL rhold_held got=%b want=1", bus.held); else n_pass++;
    #1 reset_ = 1'b0;
    #1;
    n_chk++;
    if ({bus.press_p, bus.short_p, bus.long_p, bus.rep_p, bus.held} !== 5'b0)
      $display("FAIL rhold_async got=%b want=00000",
               {bus.press_p, bus.short_p, bus.long_p, bus.rep_p, bus.held});
    else n_pass++;
    @(posedge clk);
    #1;
    reset_ = 1'b1;
    ticks(3, 1, 99, 16'h0000);
    n_chk++;
    if (bus.held !== 1'b0) $display("FAIL rhold_armed got=%b want=0", bus.held); else n_pass++;
    drive(1'b0, 1'b0);
    exp_ev(EV_PRESS);
    drive(1'b1, 1'b0);
    exp_ev(EV_SHORT);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    n_chk++;
    if (sb.size() !== 0) $display("FAIL rhold_pending got=%0d want=0", sb.size()); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_long;
    test_short;
    test_repeat;
    test_race;
    test_arm;
    test_reset_hold;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
